// File: rtl/ram_stream_loader.sv
// Boot loader: packs a byte stream into 32-bit words, writes them to consecutive RAM addresses (optional RAM_LOADER_CHECKSUM_EN trailer).
// Latency: start->in_ready 1 cycle; 4th byte accepted -> ram_is_write 1 cycle; >= 5 cycles per word.
// Backpressure: in_ready drops during the write cycle and outside a load; in_valid without in_ready is ignored.
module ram_stream_loader #(
    parameter int BIG_ENDIAN   = 0,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] base_address,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] ram_address,
    output logic [31:0] ram_in,
    output logic        ram_is_write,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
`ifdef RAM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        FINISH
    } state_t;

    state_t      state;
    logic [15:0] base_q;
    logic [15:0] count_q;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
    logic [31:0] tmo_cnt;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    logic        accept;
    logic        tmo_hit;
    logic [1:0]  lane;
    logic [31:0] asm_word;
    logic [15:0] ww_next;

    assign accept  = in_valid & in_ready;
    assign tmo_hit = (IDLE_TIMEOUT > 0) && (tmo_cnt == 32'(IDLE_TIMEOUT - 1));
    assign lane    = (BIG_ENDIAN != 0) ? ~byte_idx : byte_idx;
    assign ww_next = words_written + 16'd1;

    // Word as it will look once the byte currently on in_data lands in its lane.
    always_comb begin
        asm_word = word_buf;
        asm_word[{lane, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            ram_address   <= '0;
            ram_in        <= '0;
            ram_is_write  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            base_q        <= '0;
            count_q       <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            tmo_cnt       <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q        <= base_address;
                        count_q       <= word_count;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        words_written <= '0;
                        byte_idx      <= '0;
                        tmo_cnt       <= '0;
                        busy          <= 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
                        csum          <= '0;
                        in_ready      <= 1'b1;
                        state         <= (word_count != 16'd0) ? RECV : CSUM;
`else
                        if (word_count != 16'd0) begin
                            in_ready <= 1'b1;
                            state    <= RECV;
                        end else begin
                            state    <= FINISH;
                        end
`endif
                    end
                end
                RECV
`ifdef RAM_LOADER_CHECKSUM_EN
                , CSUM
`endif
                : begin
                    if (accept) begin
                        word_buf <= asm_word;
                        byte_idx <= byte_idx + 2'd1;
                        tmo_cnt  <= '0;
                        if (byte_idx == 2'd3) begin
                            in_ready <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
                            if (state == CSUM) begin
                                error <= (asm_word != csum);
                                state <= FINISH;
                            end else
`endif
                            begin
                                ram_is_write <= 1'b1;
                                ram_address  <= base_q + words_written;
                                ram_in       <= asm_word;
                                state        <= WRITE;
                            end
                        end
                    end else if (tmo_hit) begin
                        // Abort drops any partial word; words_written keeps committed count.
                        error    <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                WRITE: begin
                    ram_is_write  <= 1'b0;
                    words_written <= ww_next;
`ifdef RAM_LOADER_CHECKSUM_EN
                    csum          <= csum + ram_in;
                    in_ready      <= 1'b1;
                    state         <= (ww_next == count_q) ? CSUM : RECV;
`else
                    if (ww_next == count_q) begin
                        state    <= FINISH;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= RECV;
                    end
`endif
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed + randomized bench for ram_stream_loader (BIG_ENDIAN=0, IDLE_TIMEOUT=8) with a word-level RAM reference.
module tb_ram_stream_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [15:0] base_address, word_count;
    logic [7:0]  in_data;
    logic        in_ready, ram_is_write, busy, done, error;
    logic [15:0] ram_address, words_written;
    logic [31:0] ram_in;

    always #5 clk = ~clk;

    ram_stream_loader #(.BIG_ENDIAN(0), .IDLE_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_address(base_address), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_address(ram_address), .ram_in(ram_in), .ram_is_write(ram_is_write),
        .busy(busy), .done(done), .error(error), .words_written(words_written)
    );

    int checks = 0;
    int errors = 0;

    // RAM model: captures writes on the negedge like the real RAM.
    logic [31:0] dut_mem [int];
    int unsigned wr_total = 0;
    always @(negedge clk) begin
        if (ram_is_write === 1'b1) begin
            dut_mem[int'(ram_address)] = ram_in;
            wr_total++;
        end
    end

    logic [7:0] bq [$];

    function automatic logic [31:0] mem_rd(input int a);
        return dut_mem.exists(a) ? dut_mem[a] : 32'hxxxxxxxx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        logic got;
        got = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 40 && !got; i++) begin
            r = in_ready;
            tick();
            got = r;
        end
        in_valid = 1'b0;
        check("byte_accepted", 32'(got), 32'd1);
    endtask

    // Full load: bytes come from bq; expected words built as little-endian packing.
    task automatic do_load(input logic [15:0] base, input logic [15:0] cnt,
                           input int mingap, input int maxgap, input bit poke, input bit bad_sum);
        int unsigned w0;
        logic [31:0] sum, word;
        logic [7:0]  b [4];
        logic [15:0] a;
        logic        seen;
        w0  = wr_total;
        sum = 32'd0;
        base_address = base;
        word_count   = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_address = 16'($urandom);
        word_count   = 16'($urandom);
        check("start_done_clear", 32'(done), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        for (int w = 0; w < int'(cnt); w++) begin
            for (int k = 0; k < 4; k++) begin
                b[k] = bq.pop_front();
                send_byte(b[k], int'($urandom_range(maxgap, mingap)));
                if (poke && w == 0 && k == 1) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
            end
            word = {b[3], b[2], b[1], b[0]};
            a    = base + 16'(w);
            sum  = sum + word;
            check("wr_strobe", 32'(ram_is_write), 32'd1);
            check("wr_addr", 32'(ram_address), 32'(a));
            check("wr_data", ram_in, word);
            tick();
            check("wr_single", 32'(ram_is_write), 32'd0);
            check("wr_mem", mem_rd(int'(a)), word);
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        if (bad_sum) sum = sum + 32'd1;
        for (int k = 0; k < 4; k++) send_byte(sum[8*k +: 8], int'($urandom_range(maxgap, mingap)));
`endif
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        check("done", 32'(done), 32'd1);
`ifdef RAM_LOADER_CHECKSUM_EN
        check("error", 32'(error), 32'(bad_sum));
`else
        check("error", 32'(error), 32'd0);
`endif
        check("busy_end", 32'(busy), 32'd0);
        check("in_ready_end", 32'(in_ready), 32'd0);
        check("words_written", 32'(words_written), 32'(cnt));
        check("write_count", wr_total - w0, 32'(cnt));
    endtask

    initial begin
        int unsigned w0;
        logic [7:0] b [5];
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        base_address = 16'd0; word_count = 16'd0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wr", 32'(ram_is_write), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_data", ram_in, 32'd0);
        check("rst_ww", 32'(words_written), 32'd0);
        reset = 1'b0;
        tick();

        // Basic load with fixed bytes.
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_load(16'h0010, 16'd2, 0, 0, 1'b0, 1'b0);
        check("basic_w0", mem_rd(16), 32'h44332211);
        check("basic_w1", mem_rd(17), 32'h88776655);

        // Address wrap with valid toggling every other cycle.
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        do_load(16'hFFFF, 16'd2, 1, 1, 1'b0, 1'b0);

        // Start pulsed mid-load must be ignored.
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        do_load(16'h0400, 16'd3, 0, 2, 1'b1, 1'b0);

        // Randomized loads.
        for (int n = 0; n < 5; n++) begin
            logic [15:0] rb, rc;
            rb = 16'($urandom);
            rc = 16'($urandom_range(4, 1));
            for (int i = 0; i < 4 * int'(rc); i++) bq.push_back(8'($urandom));
            do_load(rb, rc, 0, 3, 1'b0, 1'b0);
        end

        // Empty load.
`ifdef RAM_LOADER_CHECKSUM_EN
        do_load(16'h0500, 16'd0, 0, 0, 1'b0, 1'b0);
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load(16'h0600, 16'd2, 0, 1, 1'b0, 1'b0);
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        w0 = wr_total;
        do_load(16'h0700, 16'd2, 0, 1, 1'b0, 1'b1);
        check("csum_not_written", mem_rd(16'h0702), 32'hxxxxxxxx);
`else
        w0 = wr_total;
        base_address = 16'h0500;
        word_count   = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("empty_done", 32'(done), 32'd1);
        check("empty_ww", 32'(words_written), 32'd0);
        tick();
        check("empty_nowrite", wr_total - w0, 32'd0);
`endif

        // Reset after two bytes of word 0.
        w0 = wr_total;
        base_address = 16'h0200;
        word_count   = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_wr", 32'(ram_is_write), 32'd0);
        repeat (3) tick();
        check("mid_rst_nowrite", wr_total - w0, 32'd0);
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        do_load(16'h0200, 16'd1, 0, 1, 1'b0, 1'b0);

        // Timeout: one full word, one byte, then stall.
        w0 = wr_total;
        base_address = 16'h0300;
        word_count   = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b[k] = 8'($urandom);
            send_byte(b[k], 0);
            if (k == 3) begin
                check("tmo_wr_strobe", 32'(ram_is_write), 32'd1);
                tick();
            end
        end
        repeat (7) tick();
        check("tmo_early", 32'(error), 32'd0);
        tick();
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_done", 32'(done), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_ready", 32'(in_ready), 32'd0);
        check("tmo_ww", 32'(words_written), 32'd1);
        repeat (4) tick();
        check("tmo_writes", wr_total - w0, 32'd1);
        check("tmo_mem", mem_rd(16'h0300), {b[3], b[2], b[1], b[0]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
